pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum consecutive data-memory wait cycles before fault.
REQ-002 SHALL have parameter CNT_W, default 32: stall_count width.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  5  EX load destination.
- ex_branch_taken, ex_jump  in  1  control transfer resolved in EX.
- mem_req  in  1  MEM stage has an active load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register write enables.
- if_id_flush, id_ex_flush  out  1  insert bubble into IF/ID / ID/EX.
- mem_fault  out  1  sticky memory-timeout flag.
- stall_count  out  CNT_W  cycles with pc_en=0.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-005 load_use SHALL be ex_mem_read & ex_rt!=0 & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)); combinational.
REQ-006 mem_stall SHALL be mem_req & !dmem_ready; combinational, in RUN and MEM_WAIT.
REQ-007 Priority SHALL be: FAULT > mem_stall > branch/jump flush > load_use.
REQ-008 mem_stall: all five enables 0, both flushes 0; same-cycle response, zero latency.
REQ-009 Flush (ex_branch_taken|ex_jump, no mem_stall): all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-010 load_use (no flush, no mem_stall): pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1; exactly one bubble per hazard.
REQ-011 Simultaneous flush and load_use SHALL resolve as flush only.
REQ-012 No condition: all enables 1, flushes 0.
REQ-013 RUN->MEM_WAIT when mem_stall; wait_cnt loads 1.
REQ-014 In MEM_WAIT: dmem_ready=1 -> RUN, wait_cnt cleared; else wait_cnt increments.
REQ-015 When wait_cnt==MEM_TIMEOUT and dmem_ready=0 -> FAULT; mem_fault=1 next cycle.
REQ-016 dmem_ready asserted in the same cycle the timeout is reached SHALL win: return to RUN, no fault.
REQ-017 Branch/jump inputs arriving during MEM_WAIT stay frozen in EX; the flush SHALL take effect in the first cycle after the wait ends.
REQ-018 FAULT: all enables 0, flushes 0, mem_fault=1; only reset exits.
REQ-019 stall_count SHALL increment when pc_en=0 in RUN or MEM_WAIT, SHALL saturate at all-ones, SHALL not count in FAULT.

Reset
REQ-020 While reset=1, outputs SHALL be: all enables 0, if_id_flush=1, id_ex_flush=1.
REQ-021 On the reset edge: state=RUN, wait_cnt=0, mem_fault=0, stall_count=0.
REQ-022 Reset mid-MEM_WAIT or in FAULT SHALL fully abandon the wait; the first cycle after reset is RUN.

Structure
REQ-023 FSM state encodings and the default MEM_TIMEOUT SHALL live in the shared CPU constants package, next to the opcode/funct constants.
REQ-024 The load_use comparator SHALL be a combinational sub-module, hazard_detect.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; ex_rt=0 -> no stall.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- mem_req=1, dmem_ready low 3 cycles -> enables 0 for 3 cycles, stall_count=3, RUN on the 4th cycle.
- MEM_TIMEOUT=4, dmem_ready never high -> mem_fault=1 after 4 wait cycles; stays 1; reset clears it.
- dmem_ready=1 on the timeout cycle -> no fault; ex_branch_taken held during the wait -> flush on the first cycle after.
- stall_count with CNT_W=4 forced past 15 -> stays at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU constants: instruction opcode/funct fields, the pipeline
// control FSM state encoding and the default data-memory timeout.
package pipeline_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Pipeline control FSM
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } pipe_state_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator (combinational).
// Ports: id_rs/id_rt + id_uses_rs/id_uses_rt describe the ID instruction's
// sources; ex_mem_read/ex_rt describe a load in EX; load_use flags that the
// ID instruction needs the loaded value before it is available.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((id_uses_rs && (ex_rt == id_rs)) ||
                (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller.
// Inputs: ID source registers, EX load info, EX control transfer, MEM
// request and data-memory ready. Outputs: write enables for the PC and the
// four pipeline registers, IF/ID and ID/EX bubble inserts, a sticky memory
// timeout flag and a saturating count of cycles the PC was held.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_t       state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              load_use;
  logic              mem_stall;
  logic              ctrl_xfer;
  logic              count_stall;

  hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !dmem_ready;
  assign ctrl_xfer = ex_branch_taken || ex_jump;
  assign mem_fault = (state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (count_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;

    // Pipeline register control, highest priority first. A branch held in
    // EX during a memory wait is acted on in the first unstalled cycle.
    if ((state == FAULT) || mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ctrl_xfer) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    count_stall = (state != FAULT) && !pc_en;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_next = FAULT;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = RUN;
    endcase

    // Reset overrides the datapath controls: freeze and drain everything.
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default parameters, and
// MEM_TIMEOUT=4/CNT_W=4) share stimulus and are checked every cycle against
// a behavioural model, plus a vector table and directed sequences.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       ex_branch_taken, ex_jump, mem_req, dmem_ready;

  logic pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic if_id_flush_a, id_ex_flush_a, mem_fault_a;
  logic [31:0] stall_count_a;
  logic pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic if_id_flush_b, id_ex_flush_b, mem_fault_b;
  logic [3:0] stall_count_b;

  pipeline_ctrl dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a),
    .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
    .mem_fault(mem_fault_a), .stall_count(stall_count_a)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b),
    .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
    .mem_fault(mem_fault_b), .stall_count(stall_count_b)
  );

  // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                  if_id_flush_a, id_ex_flush_a};
  assign ctl_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                  if_id_flush_b, id_ex_flush_b};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per instance, consecutive stalled cycles endured,
  // sticky fault, and count of held-PC cycles.
  int unsigned tmo[2]  = '{16, 4};
  longint      cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int unsigned m_wait[2];
  bit          m_fault[2];
  longint      m_cnt[2];

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] ert;
    logic       br, jp;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_lu();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic logic [6:0] f_ctl(input bit flt);
    if (reset) return 7'b0000011;
    if (flt || (mem_req && !dmem_ready)) return 7'b0000000;
    if (ex_branch_taken || ex_jump) return 7'b1111111;
    if (f_lu()) return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic sample();
    @(negedge clk);
    check("ctl_a",   {57'd0, ctl_a}, {57'd0, f_ctl(m_fault[0])});
    check("fault_a", {63'd0, mem_fault_a}, {63'd0, m_fault[0]});
    check("cnt_a",   {32'd0, stall_count_a}, m_cnt[0]);
    check("ctl_b",   {57'd0, ctl_b}, {57'd0, f_ctl(m_fault[1])});
    check("fault_b", {63'd0, mem_fault_b}, {63'd0, m_fault[1]});
    check("cnt_b",   {60'd0, stall_count_b}, m_cnt[1]);
  endtask

  task automatic advance();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      e = f_ctl(m_fault[i]);
      if (reset) begin
        m_wait[i]  = 0;
        m_fault[i] = 1'b0;
        m_cnt[i]   = 0;
      end else if (!m_fault[i]) begin
        if (!e[6] && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (mem_req && !dmem_ready) begin
          if (m_wait[i] == tmo[i]) m_fault[i] = 1'b1;
          else m_wait[i]++;
        end else begin
          m_wait[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = '0; ex_branch_taken = 0; ex_jump = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    sample();
    advance();
    reset = 0;
  endtask

  initial begin
    tbl[0] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 7'b1111100};
    tbl[1] = '{5'd8, 5'd3, 1, 0, 1, 5'd8, 0, 0, 7'b0011101};
    tbl[2] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 7'b1111100};
    tbl[3] = '{5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 7'b0011101};
    tbl[4] = '{5'd1, 5'd5, 1, 0, 1, 5'd5, 0, 0, 7'b1111100};
    tbl[5] = '{5'd8, 5'd8, 1, 1, 0, 5'd8, 0, 0, 7'b1111100};
    tbl[6] = '{5'd2, 5'd3, 1, 1, 0, 5'd9, 1, 0, 7'b1111111};
    tbl[7] = '{5'd7, 5'd3, 1, 0, 1, 5'd7, 0, 1, 7'b1111111};
    tbl[8] = '{5'd8, 5'd3, 1, 0, 1, 5'd8, 1, 0, 7'b1111111};

    clear_in();
    reset = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_fault[i] = 0; m_cnt[i] = 0;
    end

    // Reset state
    sample();
    check("reset_ctl", {57'd0, ctl_a}, 64'h03);
    advance();
    reset = 0;

    // Vector table in RUN, no memory activity
    for (int i = 0; i < 9; i++) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt;
      id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt;
      ex_mem_read = tbl[i].mr; ex_rt = tbl[i].ert;
      ex_branch_taken = tbl[i].br; ex_jump = tbl[i].jp;
      sample();
      check("table_ctl_a", {57'd0, ctl_a}, {57'd0, tbl[i].exp});
      check("table_ctl_b", {57'd0, ctl_b}, {57'd0, tbl[i].exp});
      advance();
    end

    // Memory stall for 3 cycles, then ready
    do_reset();
    mem_req = 1; dmem_ready = 0;
    repeat (3) begin
      sample();
      check("memstall_ctl", {57'd0, ctl_a}, 64'h00);
      advance();
    end
    dmem_ready = 1;
    sample();
    check("memstall_release_ctl", {57'd0, ctl_a}, 64'h7C);
    check("memstall_count", {32'd0, stall_count_a}, 64'd3);
    advance();

    // Timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    mem_req = 1; dmem_ready = 0;
    repeat (5) begin
      sample();
      advance();
    end
    sample();
    check("timeout_fault_b", {63'd0, mem_fault_b}, 64'd1);
    check("timeout_nofault_a", {63'd0, mem_fault_a}, 64'd0);
    advance();
    mem_req = 0; dmem_ready = 1;
    repeat (3) begin
      sample();
      check("fault_sticky", {63'd0, mem_fault_b}, 64'd1);
      check("fault_ctl", {57'd0, ctl_b}, 64'h00);
      advance();
    end
    reset = 1;
    sample();
    advance();
    reset = 0;
    sample();
    check("fault_cleared", {63'd0, mem_fault_b}, 64'd0);
    advance();

    // Ready arrives on the timeout cycle with a branch held in EX
    do_reset();
    mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
    repeat (4) begin
      sample();
      advance();
    end
    dmem_ready = 1;
    sample();
    check("late_ready_flush", {57'd0, ctl_b}, 64'h7F);
    advance();
    clear_in();
    sample();
    check("late_ready_nofault", {63'd0, mem_fault_b}, 64'd0);
    advance();

    // Saturation of a 4-bit stall counter under a held load-use hazard
    do_reset();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    repeat (20) begin
      sample();
      advance();
    end
    sample();
    check("sat_count_b", {60'd0, stall_count_b}, 64'd15);
    check("sat_count_a", {32'd0, stall_count_a}, 64'd20);
    advance();

    // Reset in the middle of a wait discards the accumulated wait
    do_reset();
    mem_req = 1; dmem_ready = 0;
    repeat (3) begin
      sample();
      advance();
    end
    reset = 1;
    sample();
    advance();
    reset = 0;
    repeat (4) begin
      sample();
      advance();
    end
    sample();
    check("reset_mid_wait_nofault", {63'd0, mem_fault_b}, 64'd0);
    dmem_ready = 1;
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 99) < 2);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 99) < 50);
      ex_rt           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 99) < 10);
      ex_jump         = ($urandom_range(0, 99) < 5);
      mem_req         = ($urandom_range(0, 99) < 35);
      dmem_ready      = ($urandom_range(0, 99) < 40);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
